// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches against a fixed
// one-cycle-latency instruction memory and buffers the returned words for decode.
module prefetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0] out_pc,
    input  logic                  out_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0]         PTR_ONE   = 1;
    localparam logic [CW-1:0]         CNT_ONE   = 1;
    localparam logic [CW:0]           DEPTH_OCC = DEPTH[CW:0];
    localparam logic [DATA_WIDTH-1:0] PC_STEP   = 4;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] tag_q, tag_d;
    logic                  inflight_q, inflight_d;
    logic                  discard_q, discard_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] instr_q [DEPTH];
    logic [DATA_WIDTH-1:0] instr_d [DEPTH];
    logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
    logic [DATA_WIDTH-1:0] pc_d    [DEPTH];

    logic [CW:0] occupancy;
    logic        push;
    logic        pop;

    // Outstanding fetch counts against capacity so its response always has a slot.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        imem_req  = !rst && !redirect && (occupancy < DEPTH_OCC);
        imem_addr = fetch_pc_q;
        out_valid = !rst && (count_q != '0);
        out_instr = instr_q[head_q];
        out_pc    = pc_q[head_q];
        push      = inflight_q && !discard_q;
        pop       = out_valid && out_ready;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_d      = tag_q;
        inflight_d = imem_req;
        discard_d  = 1'b0;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        instr_d    = instr_q;
        pc_d       = pc_q;

        if (imem_req) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            tag_d      = fetch_pc_q;
        end
        if (push) begin
            instr_d[tail_q] = imem_rdata;
            pc_d[tail_q]    = tag_q;
            tail_d          = tail_q + PTR_ONE;
        end
        if (pop) begin
            head_d = head_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Flush after any same-cycle handshake; the consumer keeps that word.
        if (redirect) begin
            fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            discard_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

endmodule
